// File: rtl/sys_cmd_ctrl.sv
// rtl/sys_cmd_ctrl.sv - host byte-frame command parser driving register file, ALU and UART TX
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int FUN_WIDTH     = 4,
    parameter int OUT_WIDTH     = 16,
    parameter int FRAME_TIMEOUT = 4096
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic                     WR_EN,
    output logic                     RD_EN,
    output logic [ADDRESS_WIDTH-1:0] ADDRESS,
    output logic [DATA_WIDTH-1:0]    WR_DATA,
    input  logic [DATA_WIDTH-1:0]    RD_DATA,
    input  logic                     RD_DATA_VLD,
    output logic                     ALU_EN,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    input  logic [OUT_WIDTH-1:0]     ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_READY
);

    localparam int CNT_W = $clog2(FRAME_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_OP_A,
        S_OP_B, S_FUN, S_ALU_WAIT, S_TX_LO, S_TX_HI
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     wr_en_q, wr_en_d;
    logic                     rd_en_q, rd_en_d;
    logic                     alu_en_q, alu_en_d;
    logic                     gate_q, gate_d;
    logic                     tx_vld_q, tx_vld_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [FUN_WIDTH-1:0]     alu_fun_q, alu_fun_d;
    logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
    logic [DATA_WIDTH-1:0]    tx_hi_q, tx_hi_d;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        address_d = address_q;
        wr_data_d = wr_data_q;
        alu_fun_d = alu_fun_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;
        tx_hi_d   = tx_hi_q;
        case (state_q)
            S_IDLE: if (RX_D_VLD) begin
                if (RX_P_DATA == DATA_WIDTH'(8'hAA))      state_d = S_WR_ADDR;
                else if (RX_P_DATA == DATA_WIDTH'(8'hBB)) state_d = S_RD_ADDR;
                else if (RX_P_DATA == DATA_WIDTH'(8'hCC)) state_d = S_OP_A;
                else if (RX_P_DATA == DATA_WIDTH'(8'hDD)) state_d = S_FUN;
            end
            S_WR_ADDR: if (RX_D_VLD) begin
                address_d = RX_P_DATA[ADDRESS_WIDTH-1:0];
                state_d   = S_WR_DATA;
            end
            S_WR_DATA: if (RX_D_VLD) begin
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = S_IDLE;
            end
            S_RD_ADDR: if (RX_D_VLD) begin
                address_d = RX_P_DATA[ADDRESS_WIDTH-1:0];
                rd_en_d   = 1'b1;
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: if (RD_DATA_VLD) begin
                tx_data_d = RD_DATA;
                tx_vld_d  = 1'b1;
                state_d   = S_TX_HI;
            end
            S_OP_A: if (RX_D_VLD) begin
                address_d = '0;
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = S_OP_B;
            end
            S_OP_B: if (RX_D_VLD) begin
                address_d = ADDRESS_WIDTH'(1);
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = S_FUN;
            end
            S_FUN: if (RX_D_VLD) begin
                alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
                alu_en_d  = 1'b1;
                state_d   = S_ALU_WAIT;
            end
            S_ALU_WAIT: if (ALU_OUT_VLD) begin
                tx_data_d = ALU_OUT[DATA_WIDTH-1:0];
                tx_hi_d   = ALU_OUT[OUT_WIDTH-1:DATA_WIDTH];
                tx_vld_d  = 1'b1;
                state_d   = S_TX_LO;
            end
            S_TX_LO: if (TX_READY) begin
                tx_data_d = tx_hi_q;
                state_d   = S_TX_HI;
            end
            S_TX_HI: if (TX_READY) begin
                tx_vld_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Any state that makes no progress for the whole window gives up silently.
        if (state_q != S_IDLE && state_d == state_q && cnt_q == CNT_W'(FRAME_TIMEOUT - 1)) begin
            state_d  = S_IDLE;
            tx_vld_d = 1'b0;
        end
        cnt_d  = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
        // Gate opens on entering FUN so it leads ALU_EN by at least one cycle.
        gate_d = (state_d == S_FUN) || (state_d == S_ALU_WAIT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            gate_q    <= 1'b0;
            tx_vld_q  <= 1'b0;
            address_q <= '0;
            wr_data_q <= '0;
            alu_fun_q <= '0;
            tx_data_q <= '0;
            tx_hi_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            gate_q    <= gate_d;
            tx_vld_q  <= tx_vld_d;
            address_q <= address_d;
            wr_data_q <= wr_data_d;
            alu_fun_q <= alu_fun_d;
            tx_data_q <= tx_data_d;
            tx_hi_q   <= tx_hi_d;
        end
    end

    assign WR_EN       = wr_en_q;
    assign RD_EN       = rd_en_q;
    assign ADDRESS     = address_q;
    assign WR_DATA     = wr_data_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_GATE_EN = gate_q;
    assign TX_P_DATA   = tx_data_q;
    assign TX_D_VLD    = tx_vld_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb/tb_sys_cmd_ctrl.sv - directed self-checking bench for sys_cmd_ctrl
module tb_sys_cmd_ctrl;

    localparam int FT = 4096;

    logic        clk = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic        WR_EN, RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD;
    logic [3:0]  ADDRESS, ALU_FUN;
    logic [7:0]  WR_DATA, TX_P_DATA;
    logic [7:0]  RD_DATA;
    logic        RD_DATA_VLD;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        TX_READY;

    int n_vec  = 0;
    int n_fail = 0;
    int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0;
    logic [11:0] wr_log[$];
    logic [7:0]  tx_q[$];
    logic [28:0] outs;

    assign outs = {WR_EN, RD_EN, ADDRESS, WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD};

    sys_cmd_ctrl #(.FRAME_TIMEOUT(FT)) dut (
        .CLK(clk), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .WR_EN(WR_EN), .RD_EN(RD_EN), .ADDRESS(ADDRESS), .WR_DATA(WR_DATA),
        .RD_DATA(RD_DATA), .RD_DATA_VLD(RD_DATA_VLD),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_READY(TX_READY)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (WR_EN) begin
            wr_cnt++;
            wr_log.push_back({ADDRESS, WR_DATA});
        end
        if (RD_EN)  rd_cnt++;
        if (ALU_EN) alu_cnt++;
        if (TX_D_VLD && TX_READY) tx_q.push_back(TX_P_DATA);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #2;
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge clk); #2;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        @(posedge clk); #2;
        RD_DATA = d; RD_DATA_VLD = 1'b1;
        @(posedge clk); #2;
        RD_DATA = 8'h00; RD_DATA_VLD = 1'b0;
    endtask

    task automatic pulse_alu(input logic [15:0] r);
        @(posedge clk); #2;
        ALU_OUT = r; ALU_OUT_VLD = 1'b1;
        @(posedge clk); #2;
        ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int   wbase;
        logic hold_ok;
        RST = 1'b1; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
        RD_DATA = 8'h00; RD_DATA_VLD = 1'b0;
        ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0; TX_READY = 1'b1;
        idle(3);
        @(negedge clk);
        check("reset_outputs", 32'(outs), 32'h0);
        @(posedge clk); #2; RST = 1'b0;

        // Register write
        send(8'hAA); send(8'h0A); send(8'hEC);
        @(negedge clk);
        check("t1_wr_en", 32'(WR_EN), 32'h1);
        check("t1_addr", 32'(ADDRESS), 32'hA);
        check("t1_wr_data", 32'(WR_DATA), 32'hEC);
        @(negedge clk);
        check("t1_wr_single_pulse", 32'(WR_EN), 32'h0);
        idle(3);
        check("t1_wr_cnt", 32'(wr_cnt), 32'd1);
        check("t1_no_other", 32'(rd_cnt + alu_cnt + tx_q.size()), 32'd0);

        // Register read
        send(8'hBB); send(8'h0A);
        @(negedge clk);
        check("t2_rd_en", 32'(RD_EN), 32'h1);
        check("t2_addr", 32'(ADDRESS), 32'hA);
        @(posedge clk);
        pulse_rd(8'hEC);
        @(negedge clk);
        check("t2_tx_vld", 32'(TX_D_VLD), 32'h1);
        check("t2_tx_data", 32'(TX_P_DATA), 32'hEC);
        idle(3);
        check("t2_tx_count", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) check("t2_tx_byte", 32'(tx_q[0]), 32'hEC);
        check("t2_tx_idle", 32'(TX_D_VLD), 32'h0);
        check("t2_rd_cnt", 32'(rd_cnt), 32'd1);

        // ALU with operands
        tx_q.delete(); wr_log.delete();
        send(8'hCC); send(8'h0C); send(8'h04);
        @(negedge clk);
        check("t3_gate_before_alu_en", 32'(CLK_GATE_EN), 32'h1);
        check("t3_no_early_alu_en", 32'(ALU_EN), 32'h0);
        send(8'h00);
        @(negedge clk);
        check("t3_alu_en", 32'(ALU_EN), 32'h1);
        check("t3_alu_fun", 32'(ALU_FUN), 32'h0);
        pulse_alu(16'h0030);
        @(negedge clk);
        check("t3_tx_vld", 32'(TX_D_VLD), 32'h1);
        check("t3_tx_lo", 32'(TX_P_DATA), 32'h30);
        check("t3_gate_dropped", 32'(CLK_GATE_EN), 32'h0);
        idle(4);
        check("t3_wr_count", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            check("t3_wr_op_a", 32'(wr_log[0]), 32'h00C);
            check("t3_wr_op_b", 32'(wr_log[1]), 32'h104);
        end
        check("t3_tx_count", 32'(tx_q.size()), 32'd2);
        if (tx_q.size() == 2) begin
            check("t3_tx_byte0", 32'(tx_q[0]), 32'h30);
            check("t3_tx_byte1", 32'(tx_q[1]), 32'h00);
        end

        // ALU without operands, TX back-pressure
        tx_q.delete();
        TX_READY = 1'b0;
        send(8'hDD); send(8'h01);
        @(negedge clk);
        check("t4_alu_en", 32'(ALU_EN), 32'h1);
        check("t4_alu_fun", 32'(ALU_FUN), 32'h1);
        pulse_alu(16'h1234);
        hold_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!(TX_D_VLD === 1'b1 && TX_P_DATA === 8'h34)) hold_ok = 1'b0;
        end
        check("t4_tx_held_stable", 32'(hold_ok), 32'h1);
        check("t4_nothing_accepted", 32'(tx_q.size()), 32'd0);
        @(posedge clk); #2; TX_READY = 1'b1;
        idle(4);
        check("t4_tx_count", 32'(tx_q.size()), 32'd2);
        if (tx_q.size() == 2) begin
            check("t4_tx_byte0", 32'(tx_q[0]), 32'h34);
            check("t4_tx_byte1", 32'(tx_q[1]), 32'h12);
        end
        check("t4_tx_idle", 32'(TX_D_VLD), 32'h0);

        // Junk byte, slow-but-in-time data byte, then a real timeout
        send(8'h55); send(8'hAA); send(8'h03);
        idle(FT - 10);
        send(8'h3C);
        @(negedge clk);
        check("t5_late_wr_en", 32'(WR_EN), 32'h1);
        check("t5_late_wr", 32'({ADDRESS, WR_DATA}), 32'h33C);
        send(8'hAA); send(8'h03);
        idle(FT + 5);
        wbase = wr_cnt;
        send(8'h77); send(8'hAA); send(8'h05); send(8'h66);
        @(negedge clk);
        check("t5_after_timeout_wr", 32'({WR_EN, ADDRESS, WR_DATA}), 32'h1566);
        idle(2);
        check("t5_single_write", 32'(wr_cnt - wbase), 32'd1);

        // Reset while waiting on the ALU
        send(8'hDD); send(8'h02);
        @(negedge clk);
        check("t6_alu_en", 32'(ALU_EN), 32'h1);
        idle(2);
        @(negedge clk);
        check("t6_gate_in_wait", 32'(CLK_GATE_EN), 32'h1);
        @(posedge clk); #2; RST = 1'b1;
        @(posedge clk); #2; RST = 1'b0;
        @(negedge clk);
        check("t6_reset_outputs", 32'(outs), 32'h0);
        send(8'hAA); send(8'h07); send(8'h5A);
        @(negedge clk);
        check("t6_post_reset_wr", 32'({WR_EN, ADDRESS, WR_DATA}), 32'h175A);
        idle(3);
        check("alu_en_total", 32'(alu_cnt), 32'd3);
        check("rd_en_total", 32'(rd_cnt), 32'd1);
        check("no_stray_tx", 32'(tx_q.size()), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
